// File: rtl/mem_lcd_pkg.sv
// Shared types and width helpers for the memory-LCD scan engine.
package mem_lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGsp,
    StLineStart,
    StData,
    StGen,
    StSkip,
    StFrameEnd
  } state_e;

  function automatic int unsigned calc_rgb_w(input int unsigned ppe);
    return 3 * ppe;
  endfunction

  function automatic int unsigned calc_lw(input int unsigned lines);
    return $clog2(lines + 1);
  endfunction

endpackage

// File: rtl/mem_lcd_vcom_gen.sv
// VA/VB/VCOM generator: free-running half-period divider, held at zero while disabled.
module mem_lcd_vcom_gen #(
  parameter int unsigned VCOM_HALF = 833333
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vcom_en,
  output logic o_va,
  output logic o_vb,
  output logic o_vcom
);

  localparam int unsigned CW = $clog2(VCOM_HALF + 1);

  logic [CW-1:0] r_cnt;
  logic          r_va;
  logic          r_on;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(VCOM_HALF - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_va  <= 1'b0;
      r_on  <= 1'b0;
    end else if (!i_vcom_en) begin
      r_cnt <= '0;
      r_va  <= 1'b0;
      r_on  <= 1'b0;
    end else begin
      r_on <= 1'b1;
      if (w_wrap) begin
        r_cnt <= '0;
        r_va  <= ~r_va;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // r_on keeps VB low until the generator is actually running.
  assign o_va   = r_va;
  assign o_vb   = r_on & ~r_va;
  assign o_vcom = r_va;

endmodule

// File: rtl/mem_lcd_scan_engine.sv
// Memory-LCD scan/timing engine: turns a pixel-beat stream into gate/binary panel timing.
module mem_lcd_scan_engine
  import mem_lcd_pkg::*;
#(
  parameter int unsigned H_PIXELS     = 240,
  parameter int unsigned V_LINES      = 240,
  parameter int unsigned PIX_PER_EDGE = 2,
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned GEN_TICKS    = 4,
  parameter int unsigned VCOM_HALF    = 833333
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_frame_start,
  input  logic                                i_partial,
  input  logic [calc_lw(V_LINES)-1:0]         i_line_first,
  input  logic [calc_lw(V_LINES)-1:0]         i_line_last,
  input  logic                                i_vcom_en,
  input  logic [calc_rgb_w(PIX_PER_EDGE)-1:0] i_px_data,
  input  logic                                i_px_valid,
  output logic                                o_px_ready,
  output logic                                o_busy,
  output logic                                o_frame_done,
  output logic                                o_underflow,
  output logic                                o_va,
  output logic                                o_vb,
  output logic                                o_vcom,
  output logic                                o_gsp,
  output logic                                o_gck,
  output logic                                o_gen,
  output logic                                o_intb,
  output logic                                o_bsp,
  output logic                                o_bck,
  output logic [calc_rgb_w(PIX_PER_EDGE)-1:0] o_rgb
);

  localparam int unsigned RGB_W = calc_rgb_w(PIX_PER_EDGE);
  localparam int unsigned LW    = calc_lw(V_LINES);
  localparam int unsigned BEATS = H_PIXELS / PIX_PER_EDGE;
  localparam int unsigned BW    = $clog2(BEATS + 1);
  localparam int unsigned TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW    = $clog2(GEN_TICKS + 1);

  state_e            r_state;
  logic [TW-1:0]     r_tick_cnt;
  logic [LW-1:0]     r_line;
  logic [LW-1:0]     r_first;
  logic [LW-1:0]     r_last;
  logic [BW-1:0]     r_beat_cnt;
  logic [GW-1:0]     r_gen_cnt;
  logic [RGB_W-1:0]  r_rgb;
  logic              r_partial;
  logic              r_have_beat;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_underflow;
  logic              r_gsp;
  logic              r_gck;
  logic              r_gen;
  logic              r_intb;
  logic              r_bsp;
  logic              r_bck;
  logic              w_tick;
  logic              w_accept;
  logic              w_line_wr;
  logic              w_last_line;

  assign w_tick      = (r_tick_cnt == TW'(CLK_DIV - 1));
  assign o_px_ready  = (r_state == StData) && !r_have_beat;
  assign w_accept    = i_px_valid && o_px_ready;
  assign w_line_wr   = !r_partial || ((r_first <= r_line) && (r_line <= r_last));
  assign w_last_line = (r_line == LW'(V_LINES));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_line       <= '0;
      r_first      <= '0;
      r_last       <= '0;
      r_beat_cnt   <= '0;
      r_gen_cnt    <= '0;
      r_rgb        <= '0;
      r_partial    <= 1'b0;
      r_have_beat  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_gsp        <= 1'b0;
      r_gck        <= 1'b0;
      r_gen        <= 1'b0;
      r_intb       <= 1'b0;
      r_bsp        <= 1'b0;
      r_bck        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // A beat is held in r_rgb until the next tick shifts it out with a BCK edge.
      if (w_accept) begin
        r_rgb       <= i_px_data;
        r_have_beat <= 1'b1;
        if (r_beat_cnt == '0) r_bsp <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (i_frame_start) begin
            r_partial   <= i_partial;
            r_first     <= (i_line_first == '0) ? LW'(1) : i_line_first;
            r_last      <= (i_line_last > LW'(V_LINES)) ? LW'(V_LINES) : i_line_last;
            r_busy      <= 1'b1;
            r_underflow <= 1'b0;
            r_intb      <= 1'b1;
            r_state     <= StGsp;
          end
        end
        StGsp: begin
          if (w_tick) begin
            r_gsp   <= 1'b1;
            r_line  <= LW'(1);
            r_state <= StLineStart;
          end
        end
        StLineStart: begin
          if (w_tick) begin
            r_gck      <= ~r_gck;
            r_gsp      <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= w_line_wr ? StData : StSkip;
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_have_beat) begin
              r_bck       <= ~r_bck;
              r_have_beat <= 1'b0;
              r_bsp       <= 1'b0;
              r_beat_cnt  <= r_beat_cnt + BW'(1);
              if (r_beat_cnt == BW'(BEATS - 1)) r_state <= StGen;
            end else if (!w_accept) begin
              r_underflow <= 1'b1;
            end
          end
        end
        StGen: begin
          if (w_tick) begin
            if (!r_gen) begin
              r_bck     <= 1'b0;
              r_gen     <= 1'b1;
              r_gen_cnt <= GW'(1);
            end else if (r_gen_cnt == GW'(GEN_TICKS)) begin
              r_gen   <= 1'b0;
              r_line  <= w_last_line ? r_line : r_line + LW'(1);
              r_state <= w_last_line ? StFrameEnd : StLineStart;
            end else begin
              r_gen_cnt <= r_gen_cnt + GW'(1);
            end
          end
        end
        StSkip: begin
          if (w_tick) begin
            r_line  <= w_last_line ? r_line : r_line + LW'(1);
            r_state <= w_last_line ? StFrameEnd : StLineStart;
          end
        end
        StFrameEnd: begin
          if (w_tick) begin
            if (r_gck) begin
              r_gck <= 1'b0;
            end else begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  mem_lcd_vcom_gen #(
    .VCOM_HALF(VCOM_HALF)
  ) u_vcom_gen (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_vcom_en(i_vcom_en),
    .o_va     (o_va),
    .o_vb     (o_vb),
    .o_vcom   (o_vcom)
  );

  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_underflow  = r_underflow;
  assign o_gsp        = r_gsp;
  assign o_gck        = r_gck;
  assign o_gen        = r_gen;
  assign o_intb       = r_intb;
  assign o_bsp        = r_bsp;
  assign o_bck        = r_bck;
  assign o_rgb        = r_rgb;

endmodule

// File: tb/tb_mem_lcd_scan_engine.sv
// Directed bench for mem_lcd_scan_engine on a tiny 8x4 panel with fast ticks and VCOM.
module tb_mem_lcd_scan_engine;

  localparam int unsigned RGB_W = 6;
  localparam int unsigned LW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             frame_start = 1'b0;
  logic             partial = 1'b0;
  logic [LW-1:0]    line_first = '0;
  logic [LW-1:0]    line_last = '0;
  logic             vcom_en = 1'b0;
  logic [RGB_W-1:0] px_data;
  logic             px_valid = 1'b0;
  logic             px_ready, busy, frame_done, underflow, va, vb, vcom;
  logic             gsp, gck, gen, intb, bsp, bck;
  logic [RGB_W-1:0] rgb;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mem_lcd_scan_engine #(
    .H_PIXELS    (8),
    .V_LINES     (4),
    .PIX_PER_EDGE(2),
    .CLK_DIV     (2),
    .GEN_TICKS   (1),
    .VCOM_HALF   (10)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_frame_start(frame_start),
    .i_partial    (partial),
    .i_line_first (line_first),
    .i_line_last  (line_last),
    .i_vcom_en    (vcom_en),
    .i_px_data    (px_data),
    .i_px_valid   (px_valid),
    .o_px_ready   (px_ready),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_underflow  (underflow),
    .o_va         (va),
    .o_vb         (vb),
    .o_vcom       (vcom),
    .o_gsp        (gsp),
    .o_gck        (gck),
    .o_gen        (gen),
    .o_intb       (intb),
    .o_bsp        (bsp),
    .o_bck        (bck),
    .o_rgb        (rgb)
  );

  logic [18:0] all_out;
  assign all_out = {busy, frame_done, underflow, va, vb, vcom, gsp, gck, gen, intb, bsp, bck,
                    px_ready, rgb};

  // Source: beat n carries value n (mod 64).
  int unsigned beat_idx = 0;
  assign px_data = beat_idx[5:0];
  always @(posedge clk) if (px_valid && px_ready) beat_idx <= beat_idx + 1;

  // Panel pin monitor, sampled on the falling edge.
  int unsigned      bck_edges = 0, gck_toggles = 0, gen_pulses = 0, bsp_pulses = 0;
  int unsigned      done_pulses = 0;
  logic [RGB_W-1:0] bck_log [0:255];
  int unsigned      gen_at [0:63];
  logic             prev_bck = 1'b0, prev_gck = 1'b0, prev_gen = 1'b0, prev_bsp = 1'b0;

  always @(negedge clk) begin
    if (bck !== prev_bck) begin
      bck_log[bck_edges[7:0]] <= rgb;
      bck_edges <= bck_edges + 1;
    end
    if (gck !== prev_gck) gck_toggles <= gck_toggles + 1;
    if (gen && !prev_gen) begin
      gen_at[gen_pulses[5:0]] <= gck_toggles;
      gen_pulses <= gen_pulses + 1;
    end
    if (bsp && !prev_bsp) bsp_pulses <= bsp_pulses + 1;
    if (frame_done) done_pulses <= done_pulses + 1;
    prev_bck <= bck;
    prev_gck <= gck;
    prev_gen <= gen;
    prev_bsp <= bsp;
  end

  int unsigned s_beat, s_bck, s_gck, s_gen, s_bsp, s_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_beat = beat_idx;
    s_bck  = bck_edges;
    s_gck  = gck_toggles;
    s_gen  = gen_pulses;
    s_bsp  = bsp_pulses;
    s_done = done_pulses;
  endtask

  task automatic start_frame(input logic p, input logic [LW-1:0] f, input logic [LW-1:0] l);
    @(negedge clk);
    partial     = p;
    line_first  = f;
    line_last   = l;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned k;
    k = 0;
    while (!frame_done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, 32'(frame_done), 32'd1);
    check({tag, " busy low"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int unsigned k;
    k = 0;
    while (!px_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready"}, 32'(px_ready), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int unsigned beats, input int unsigned gens);
    check({tag, " beats"}, beat_idx - s_beat, beats);
    check({tag, " bck edges"}, bck_edges - s_bck, beats);
    for (int unsigned k = 0; k < beats; k++)
      check({tag, " rgb order"}, 32'(bck_log[8'(s_bck + k)]), 32'((s_beat + k) % 64));
    check({tag, " gck toggles"}, gck_toggles - s_gck, 32'd4);
    check({tag, " gen pulses"}, gen_pulses - s_gen, gens);
    check({tag, " bsp pulses"}, bsp_pulses - s_bsp, gens);
    check({tag, " done count"}, done_pulses - s_done, 32'd1);
    check({tag, " gck low"}, 32'(gck), 32'd0);
    check({tag, " bck low"}, 32'(bck), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'(all_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset outputs", 32'(all_out), 32'd0);

    // Full frame with an always-valid source.
    px_valid = 1'b1;
    snap();
    start_frame(1'b0, 3'd0, 3'd0);
    check("full busy", 32'(busy), 32'd1);
    check("full intb", 32'(intb), 32'd1);
    wait_done("full");
    check_frame("full", 16, 4);
    for (int unsigned k = 0; k < 4; k++)
      check("full gen line", gen_at[6'(s_gen + k)] - s_gck, k + 1);
    check("full underflow", 32'(underflow), 32'd0);

    // Partial window covering lines 2..3.
    snap();
    start_frame(1'b1, 3'd2, 3'd3);
    wait_done("partial");
    check_frame("partial", 8, 2);
    check("partial gen line a", gen_at[6'(s_gen)] - s_gck, 32'd2);
    check("partial gen line b", gen_at[6'(s_gen + 1)] - s_gck, 32'd3);

    // Starve the engine for 10 cycles at the start of line 1.
    snap();
    start_frame(1'b0, 3'd0, 3'd0);
    wait_ready("underflow");
    px_valid = 1'b0;
    begin
      int unsigned b0;
      b0 = bck_edges;
      repeat (10) @(negedge clk);
      check("underflow gap bck", bck_edges - b0, 32'd0);
    end
    check("underflow flag", 32'(underflow), 32'd1);
    px_valid = 1'b1;
    wait_done("underflow");
    check_frame("underflow", 16, 4);
    check("underflow sticky", 32'(underflow), 32'd1);

    // Clamped window (0 -> 1, 7 -> 4) plus a start pulse while busy that must be ignored.
    snap();
    start_frame(1'b1, 3'd0, 3'd7);
    check("clamp underflow cleared", 32'(underflow), 32'd0);
    repeat (20) @(negedge clk);
    check("ignore busy", 32'(busy), 32'd1);
    partial     = 1'b1;
    line_first  = 3'd3;
    line_last   = 3'd1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done("clamp");
    check_frame("clamp", 16, 4);
    repeat (10) @(negedge clk);
    check("ignore no restart", 32'(busy), 32'd0);

    // Inverted window: every line skipped.
    snap();
    start_frame(1'b1, 3'd3, 3'd1);
    wait_done("empty");
    check_frame("empty", 0, 0);

    // Asynchronous reset in the middle of a line, with VCOM high.
    start_frame(1'b0, 3'd0, 3'd0);
    wait_ready("midreset");
    vcom_en = 1'b1;
    repeat (12) @(negedge clk);
    check("midreset va high", 32'(va), 32'd1);
    check("midreset busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midreset outputs", 32'(all_out), 32'd0);
    check("midreset intb", 32'(intb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vcom_en = 1'b0;
    @(negedge clk);
    check("after reset idle", 32'(all_out), 32'd0);

    // VCOM: 10-cycle half period, VB complementary.
    vcom_en = 1'b1;
    repeat (9) @(negedge clk);
    check("vcom 9", 32'({va, vb, vcom}), 32'b010);
    @(negedge clk);
    check("vcom 10", 32'({va, vb, vcom}), 32'b101);
    repeat (9) @(negedge clk);
    check("vcom 19", 32'({va, vb, vcom}), 32'b101);
    @(negedge clk);
    check("vcom 20", 32'({va, vb, vcom}), 32'b010);
    repeat (5) @(negedge clk);
    vcom_en = 1'b0;
    @(negedge clk);
    check("vcom off", 32'({va, vb, vcom}), 32'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
